// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit RISC core front end: default widths,
// reset PC, opcode field position and the fetch entry record.
package core_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 16'h0000;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [3:0] opcode_of(input logic [DEF_DATA_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic en);
        logic [15:0] res;
        if (en && (value != 16'hFFFF)) begin
            res = value + 16'd1;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read combinationally
// from registered storage. DEPTH must be a power of two.
module ifu_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_r == CNT_W'(0));
    assign full  = (count_r == CNT_W'(DEPTH));
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

    // Qualify push/pop: flush discards both; a full FIFO takes a push only alongside a pop.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (flush) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_pop_s  = pop && !empty;
            do_push_s = push && (!full || do_pop_s);
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    ifu_fifo_chk #(.DEPTH(DEPTH)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .count (count_r)
    );

endmodule

// File: rtl/ifu_fifo_chk.sv
// Protocol checker for ifu_fifo: flags overflow, underflow and an
// out-of-range occupancy count.
module ifu_fifo_chk #(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
)(
    input logic             clk,
    input logic             rst,
    input logic             flush,
    input logic             push,
    input logic             pop,
    input logic             full,
    input logic             empty,
    input logic [CNT_W-1:0] count
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(!flush && push && full && !pop));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(!flush && pop && empty));

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order memory requests
// under a credit limit and buffers returned words. Optional IFU_PERF_CNT_EN adds perf counters.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter int                DEPTH    = 2,
    localparam int               CNT_W    = $clog2(DEPTH) + 1
)(
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [3:0]        out_opcode
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0]       perf_instr_cnt,
    output logic [15:0]       perf_flush_cnt,
    output logic [15:0]       perf_stall_cnt
`endif
);

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [CNT_W-1:0]  outstanding_r;
    logic [CNT_W-1:0]  discard_r;

    logic [ADDR_W-1:0] redirect_pc_even_s;
    logic              pop_s;
    logic [CNT_W:0]    credit_used_s;
    logic              req_valid_s;
    logic              accept_s;
    logic              rsp_keep_s;

    fetch_entry_t      data_push_s;
    fetch_entry_t      data_head_s;
    logic              data_empty_s;
    logic              data_full_s;
    logic [CNT_W-1:0]  data_count_s;

    fetch_entry_t      pcq_push_s;
    fetch_entry_t      pcq_head_s;
    logic              pcq_empty_s;
    logic              pcq_full_s;
    logic [CNT_W-1:0]  pcq_count_s;

    assign redirect_pc_even_s = {redirect_pc[ADDR_W-1:1], 1'b0};
    assign pop_s              = !data_empty_s && out_ready && !redirect_valid;

    // A slot being popped this cycle is already free, which keeps zero-wait
    // memory streaming at one instruction per cycle with only two entries.
    assign credit_used_s = {1'b0, data_count_s} + {1'b0, outstanding_r}
                         - {{CNT_W{1'b0}}, pop_s};
    assign req_valid_s   = !rst && !redirect_valid && (credit_used_s < (CNT_W+1)'(DEPTH));
    assign accept_s      = req_valid_s && imem_req_ready;
    assign rsp_keep_s    = imem_rsp_valid && (discard_r == CNT_W'(0)) && !redirect_valid;

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_r;

    // Build the entries pushed into the data FIFO and the request PC queue.
    always_comb begin
        data_push_s       = '{instr: {DEF_DATA_W{1'b0}}, pc: {DEF_ADDR_W{1'b0}}};
        pcq_push_s        = '{instr: {DEF_DATA_W{1'b0}}, pc: {DEF_ADDR_W{1'b0}}};
        data_push_s.instr = imem_rsp_data;
        data_push_s.pc    = pcq_head_s.pc;
        pcq_push_s.pc     = fetch_pc_r;
    end

    // Fetch PC, in-flight request count and the count of words to drop after a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= {CNT_W{1'b0}};
            discard_r     <= {CNT_W{1'b0}};
        end else begin
            if (redirect_valid) begin
                fetch_pc_r <= redirect_pc_even_s;
            end else if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + ADDR_W'(2);
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end

            case ({accept_s, imem_rsp_valid})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase

            // A response landing in the redirect cycle is already gone, so it is not counted.
            if (redirect_valid) begin
                discard_r <= outstanding_r - {{(CNT_W-1){1'b0}}, imem_rsp_valid};
            end else if (imem_rsp_valid && (discard_r != CNT_W'(0))) begin
                discard_r <= discard_r - CNT_W'(1);
            end else begin
                discard_r <= discard_r;
            end
        end
    end

    ifu_fifo #(.DEPTH(DEPTH)) u_data_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep_s),
        .push_data (data_push_s),
        .pop       (pop_s),
        .head      (data_head_s),
        .empty     (data_empty_s),
        .full      (data_full_s),
        .count     (data_count_s)
    );

    // Request PCs stay queued across redirects so every response, kept or
    // dropped, retires exactly one entry in order.
    ifu_fifo #(.DEPTH(DEPTH)) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (accept_s),
        .push_data (pcq_push_s),
        .pop       (imem_rsp_valid),
        .head      (pcq_head_s),
        .empty     (pcq_empty_s),
        .full      (pcq_full_s),
        .count     (pcq_count_s)
    );

    assign out_valid  = !data_empty_s;
    assign out_instr  = data_head_s.instr;
    assign out_pc     = data_head_s.pc;
    assign out_opcode = opcode_of(data_head_s.instr);

    logic unused_s;
    assign unused_s = ^{redirect_pc[0], pcq_head_s.instr, pcq_empty_s, pcq_full_s,
                        pcq_count_s, data_full_s};

`ifdef IFU_PERF_CNT_EN
    logic [15:0] perf_instr_r;
    logic [15:0] perf_flush_r;
    logic [15:0] perf_stall_r;

    // Saturating event counters for delivered instructions, redirects and starved cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_instr_r <= 16'h0000;
            perf_flush_r <= 16'h0000;
            perf_stall_r <= 16'h0000;
        end else begin
            perf_instr_r <= sat_inc16(perf_instr_r, pop_s);
            perf_flush_r <= sat_inc16(perf_flush_r, redirect_valid);
            perf_stall_r <= sat_inc16(perf_stall_r, out_ready && data_empty_s);
        end
    end

    assign perf_instr_cnt = perf_instr_r;
    assign perf_flush_cnt = perf_flush_r;
    assign perf_stall_cnt = perf_stall_r;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency in-order memory
// model that answers every request with 16'h1000 + address.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [3:0]  out_opcode;
`ifdef IFU_PERF_CNT_EN
    logic [15:0] perf_instr_cnt;
    logic [15:0] perf_flush_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    int checks_total  = 0;
    int checks_passed = 0;
    int lat = 1;
    int cyc = 0;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_opcode     (out_opcode)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_instr_cnt (perf_instr_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Memory model: acts mid-cycle on stable request signals; a request
    // accepted in cycle n is answered in cycle n + lat. Cleared by rst.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 16'h0000;
        end else begin
            if (mq.size() > 0 && mq[0].due == cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mq[0].addr + 16'h1000;
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                mq.push_back('{imem_req_addr, cyc + lat});
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_out(input int max_cyc);
        int n = 0;
        while (out_valid !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        chk("wait_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic chk_out(input string tag, input logic [15:0] pc, input logic [15:0] instr);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_pc"}, {16'd0, out_pc}, {16'd0, pc});
        chk({tag, "_instr"}, {16'd0, out_instr}, {16'd0, instr});
        chk({tag, "_opcode"}, {28'd0, out_opcode}, {28'd0, instr[15:12]});
    endtask

    initial begin
        logic [15:0] wrap_pc  [4];
        logic [15:0] wrap_ins [4];
        wrap_pc  = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
        wrap_ins = '{16'h0FFC, 16'h0FFE, 16'h1000, 16'h1002};

        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        imem_req_ready = 1'b1;
        tick(); tick();
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_perf_instr", {16'd0, perf_instr_cnt}, 32'd0);
        chk("rst_perf_flush", {16'd0, perf_flush_cnt}, 32'd0);
        chk("rst_perf_stall", {16'd0, perf_stall_cnt}, 32'd0);
`endif

        // Back-pressure: exactly two words fetched, then requests stop.
        rst = 1'b0; out_ready = 1'b0; #1;
        chk("bp_first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("bp_first_req_addr", {16'd0, imem_req_addr}, 32'h0000);
        repeat (10) tick();
        chk("bp_req_stalled", {31'd0, imem_req_valid}, 32'd0);
        chk_out("bp_hold", 16'h0000, 16'h1000);
        out_ready = 1'b1; #1;
        chk("bp_release_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("bp_release_req_addr", {16'd0, imem_req_addr}, 32'h0004);
        tick(); chk_out("bp_pc2", 16'h0002, 16'h1002);
        tick(); chk_out("bp_pc4", 16'h0004, 16'h1004);
        tick(); chk_out("bp_pc6", 16'h0006, 16'h1006);

        // Zero-wait streaming from reset: one instruction per cycle.
        rst = 1'b1; tick();
        rst = 1'b0; out_ready = 1'b1; #1;
        chk("st_req_addr0", {16'd0, imem_req_addr}, 32'h0000);
        tick(); chk("st_latency_gap", {31'd0, out_valid}, 32'd0);
        tick(); chk_out("st_pc0", 16'h0000, 16'h1000);
        tick(); chk_out("st_pc2", 16'h0002, 16'h1002);
        tick(); chk_out("st_pc4", 16'h0004, 16'h1004);
        tick(); chk_out("st_pc6", 16'h0006, 16'h1006);

        // Redirect coinciding with a handshake and a response; odd target is aligned.
        redirect_valid = 1'b1; redirect_pc = 16'h0081; #1;
        chk("rd_no_req", {31'd0, imem_req_valid}, 32'd0);
        tick(); redirect_valid = 1'b0; #1;
        chk("rd_flushed", {31'd0, out_valid}, 32'd0);
        chk("rd_req_addr", {16'd0, imem_req_addr}, 32'h0080);
        tick(); chk("rd_gap", {31'd0, out_valid}, 32'd0);
        tick(); chk_out("rd_pc80", 16'h0080, 16'h1080);
        tick(); chk_out("rd_pc82", 16'h0082, 16'h1082);

        // Redirect near the top of the address space: PC wraps to zero.
        redirect_valid = 1'b1; redirect_pc = 16'hFFFC; #1;
        tick(); redirect_valid = 1'b0; #1;
        chk("wr_flushed", {31'd0, out_valid}, 32'd0);
        chk("wr_req_addr", {16'd0, imem_req_addr}, 32'hFFFC);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("wr_%0d", i), wrap_pc[i], wrap_ins[i]);
        end

        // Latency 3: redirect with two requests in flight drops both late words.
        rst = 1'b1; lat = 3; tick();
        rst = 1'b0; out_ready = 1'b1; #1;
        chk("l3_req_addr0", {16'd0, imem_req_addr}, 32'h0000);
        tick(); tick();
        chk("l3_credit_stall", {31'd0, imem_req_valid}, 32'd0);
        redirect_valid = 1'b1; redirect_pc = 16'h0040; #1;
        tick(); redirect_valid = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("l3_drop_%0d", i), {31'd0, out_valid}, 32'd0);
            tick();
        end
        chk_out("l3_pc40", 16'h0040, 16'h1040);

        // Reset mid-stream with requests outstanding.
        rst = 1'b1; tick();
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_req_valid", {31'd0, imem_req_valid}, 32'd0);
`ifdef IFU_PERF_CNT_EN
        chk("mr_perf_instr", {16'd0, perf_instr_cnt}, 32'd0);
        chk("mr_perf_flush", {16'd0, perf_flush_cnt}, 32'd0);
        chk("mr_perf_stall", {16'd0, perf_stall_cnt}, 32'd0);
`endif
        rst = 1'b0; #1;
        chk("mr_req_addr", {16'd0, imem_req_addr}, 32'h0000);
        wait_out(10);
        chk_out("mr_first", 16'h0000, 16'h1000);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of the datapath/control pair of the 16-bit RISC core.
- Owns the fetch PC and issues in-order requests to instruction memory.
- Buffers returned instruction words in a small prefetch FIFO.
- Presents one instruction per cycle, with its PC and 4-bit opcode, over a valid/ready handshake.
- Accepts a redirect (taken beq/bne, jump) that flushes buffered and in-flight fetches.

Parameters:
ADDR_W, 16, fetch address width (byte address)
DATA_W, 16, instruction width
RESET_PC, 16'h0000, PC value loaded on reset
DEPTH, 2, prefetch FIFO entries (power of two, 2..8)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  ADDR_W  fetch byte address
imem_rsp_valid  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance, never back-pressured
imem_rsp_data  in  DATA_W  instruction word
redirect_valid  in  1  taken branch/jump from datapath; single-cycle pulse
redirect_pc  in  ADDR_W  new fetch address
out_valid  out  1  instruction available
out_ready  in  1  downstream consumes this cycle
out_instr  out  DATA_W  instruction word (FIFO head)
out_pc  out  ADDR_W  byte address of out_instr
out_opcode  out  4  out_instr[15:12]

Behaviour:
- Reset (rst=1 at clk edge):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0.
  - imem_req_valid=0 and out_valid=0 in the cycle after reset.
  - Reset mid-operation drops everything; responses arriving after reset for pre-reset requests are ignored via discard count cleared. Memory is reset alongside.
- Request issue:
  - imem_req_valid=1 when !rst && !redirect_valid && (occupancy + outstanding) < DEPTH.
  - imem_req_addr=fetch_pc.
  - On accept (valid&&ready): fetch_pc += 2 (mod 2^ADDR_W, wraps 16'hFFFE -> 16'h0000); outstanding++.
  - The request PC is also pushed into an internal PC queue.
- Response:
  - On imem_rsp_valid: outstanding--.
  - If discard>0: discard-- and drop the word.
  - Otherwise write {word, pc} into the FIFO.
  - Credit rule guarantees the FIFO never overflows; an overflow is a design error (assertion).
- Output:
  - out_valid = FIFO non-empty; out_* driven from head (registered storage, combinational read).
  - Pop on out_valid && out_ready.
  - Latency: request accept to out_valid >= 2 cycles (mem latency + 1 FIFO write cycle); no bypass.
  - Throughput 1 instr/cycle with zero-wait memory and DEPTH>=2.
- Redirect (has priority over all other events in that cycle):
  - FIFO flushed, pop ignored.
  - fetch_pc=redirect_pc.
  - discard = outstanding minus any response arriving that same cycle.
  - No request issued that cycle.
  - out_valid=0 the following cycle.
- Simultaneous push/pop with FIFO full is legal only when credits allow; occupancy unchanged.
- redirect_pc[0]=1: bit 0 is forced to 0.
- outstanding and discard counters are sized clog2(DEPTH)+1 bits.

Optional Feature:
IFU_PERF_CNT_EN
- Defined: adds outputs perf_instr_cnt[15:0] (increments on each out handshake), perf_flush_cnt[15:0] (increments on each redirect), and perf_stall_cnt[15:0] (cycles with out_ready=1 && out_valid=0). All counters saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package core_pkg holds:
  - ADDR_W/DATA_W defaults.
  - RESET_PC.
  - Opcode field position constants OPC_MSB=15, OPC_LSB=12.
  - typedef fetch_entry_t {instr, pc}.
- One sub-module: ifu_fifo, a parameterised synchronous FIFO of fetch_entry_t with flush, push, pop, count. Reused for the internal PC queue.

Test Plan:
- Reset then zero-wait memory returning 16'h1000+addr, out_ready=1 -> out_pc sequence 0,2,4,6 on consecutive cycles from cycle 3; out_opcode=4'h1.
- Hold out_ready=0 for 10 cycles -> exactly DEPTH=2 requests outstanding/buffered, imem_req_valid=0, no loss; releasing out_ready yields pc 0,2 then 4.
- Memory latency 3 cycles, redirect_valid with redirect_pc=16'h0040 while 2 requests outstanding -> both late responses dropped; next out_pc=16'h0040.
- Redirect in the same cycle as out handshake and an imem response -> pop ignored, response discarded, next out_pc = redirect_pc.
- Redirect to 16'hFFFC -> out_pc FFFC, FFFE, 0000, 0002 (wrap).
- Assert rst mid-stream with outstanding requests -> out_valid=0 next cycle; first output afterwards has pc=RESET_PC. With IFU_PERF_CNT_EN, all counters read 0.
